// File: rtl/fp_cmp_pkg.sv
// fp_cmp_pkg: shared encodings for the FloPoCo float comparator.
// Exception classes, op codes and width helpers.
package fp_cmp_pkg;

  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_e;

  typedef enum logic [2:0] {
    OP_LT = 3'd0,
    OP_LE = 3'd1,
    OP_EQ = 3'd2,
    OP_NE = 3'd3,
    OP_GT = 3'd4,
    OP_GE = 3'd5
  } op_e;

  localparam int WE_DEF = 5;
  localparam int WF_DEF = 11;

  // Operand width: exn(2) + sign(1) + exp + frac.
  function automatic int op_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

  // Magnitude key width: class(2) + exp + frac.
  function automatic int key_width(input int we, input int wf);
    return we + wf + 2;
  endfunction

endpackage

// File: rtl/fp_key_unpack.sv
// fp_key_unpack: splits a FloPoCo operand into sign, NaN flag
// and an unsigned magnitude key ordered zero < normal < inf.
module fp_key_unpack #(
  parameter int WE = 5,
  parameter int WF = 11
) (
  input  logic [WE+WF+2:0] x,
  output logic             sign,
  output logic             nan,
  output logic             zero,
  output logic [WE+WF+1:0] key
);
  import fp_cmp_pkg::*;

  localparam int W  = op_width(WE, WF);
  localparam int KW = key_width(WE, WF);

  logic [1:0]    exn;
  logic [WE-1:0] exp_f;
  logic [WF-1:0] frac_f;

  assign exn    = x[W-1:W-2];
  assign sign   = x[W-3];
  assign exp_f  = x[WE+WF-1:WF];
  assign frac_f = x[WF-1:0];

  // Class decode; exp/frac only matter for normal numbers.
  always_comb begin
    nan  = 1'b0;
    zero = 1'b0;
    key  = '0;
    unique case (1'b1)
      (exn == EXN_ZERO):   zero = 1'b1;
      (exn == EXN_NORMAL): key = {2'b01, exp_f, frac_f};
      (exn == EXN_INF):    key = {2'b10, {(KW-2){1'b0}}};
      (exn == EXN_NAN):    nan = 1'b1;
      default:             key = '0;
    endcase
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage FloPoCo float comparator with
// run-time op select, unordered flag and valid/ready flow control.
module fp_compare_pipe #(
  parameter int WE    = 5,
  parameter int WF    = 11,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WE+WF+2:0] in_a,
  input  logic [WE+WF+2:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_res,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             out_unord,
  output logic [TAG_W-1:0] out_tag
);
  import fp_cmp_pkg::*;

  localparam int KW = key_width(WE, WF);

  logic          stall;
  logic          sa, sb, na, nb, za, zb;
  logic [KW-1:0] ka, kb;

  logic             s1_valid;
  logic             s1_nan;
  logic             s1_zz;
  logic             s1_sa;
  logic             s1_sb;
  logic             s1_mlt;
  logic             s1_meq;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic n_lt, n_eq, n_gt, n_un, n_res, mgt;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  fp_key_unpack #(.WE(WE), .WF(WF)) u_unpack_a (
    .x    (in_a),
    .sign (sa),
    .nan  (na),
    .zero (za),
    .key  (ka)
  );

  fp_key_unpack #(.WE(WE), .WF(WF)) u_unpack_b (
    .x    (in_b),
    .sign (sb),
    .nan  (nb),
    .zero (zb),
    .key  (kb)
  );

  // Stage 1: latch NaN/zero flags, signs and magnitude compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_nan   <= 1'b0;
      s1_zz    <= 1'b0;
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
      s1_mlt   <= 1'b0;
      s1_meq   <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_nan <= na | nb;
        s1_zz  <= za & zb;
        s1_sa  <= sa;
        s1_sb  <= sb;
        s1_mlt <= ka < kb;
        s1_meq <= ka == kb;
        s1_op  <= in_op;
        s1_tag <= in_tag;
      end
    end
  end

  // Sign resolution and op selection for stage 2.
  always_comb begin
    n_lt  = 1'b0;
    n_eq  = 1'b0;
    n_gt  = 1'b0;
    n_un  = 1'b0;
    n_res = 1'b0;
    mgt   = ~s1_mlt & ~s1_meq;
    unique case (1'b1)
      s1_nan: n_un = 1'b1;
      (!s1_nan && s1_zz): n_eq = 1'b1;
      (!s1_nan && !s1_zz && s1_sa != s1_sb): begin
        n_lt = s1_sa;
        n_gt = s1_sb;
      end
      (!s1_nan && !s1_zz && s1_sa == s1_sb && !s1_sa): begin
        n_lt = s1_mlt;
        n_eq = s1_meq;
        n_gt = mgt;
      end
      (!s1_nan && !s1_zz && s1_sa == s1_sb && s1_sa): begin
        n_lt = mgt;
        n_eq = s1_meq;
        n_gt = s1_mlt;
      end
      default: n_un = 1'b0;
    endcase
    case (s1_op)
      OP_LT:   n_res = n_lt;
      OP_LE:   n_res = n_lt | n_eq;
      OP_EQ:   n_res = n_eq;
      OP_NE:   n_res = ~n_eq;
      OP_GT:   n_res = n_gt;
      OP_GE:   n_res = n_gt | n_eq;
      default: n_res = 1'b0;
    endcase
  end

  // Stage 2: registered outputs, held while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= 1'b0;
      out_lt    <= 1'b0;
      out_eq    <= 1'b0;
      out_gt    <= 1'b0;
      out_unord <= 1'b0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_res   <= n_res;
        out_lt    <= n_lt;
        out_eq    <= n_eq;
        out_gt    <= n_gt;
        out_unord <= n_un;
        out_tag   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_compare_pipe.sv
// tb_fp_compare_pipe: directed vectors for the float comparator.
// Flags are packed as {res,lt,eq,gt,unord}.
module tb_fp_compare_pipe;

  localparam int WE = 5;
  localparam int WF = 11;
  localparam int TW = 4;
  localparam int W  = WE + WF + 3;

  localparam logic [W-1:0] P1  = 19'h27800;
  localparam logic [W-1:0] P2  = 19'h28000;
  localparam logic [W-1:0] N1  = 19'h37800;
  localparam logic [W-1:0] PZ  = 19'h00000;
  localparam logic [W-1:0] NZ  = 19'h10000;
  localparam logic [W-1:0] NI  = 19'h50000;
  localparam logic [W-1:0] NAN = 19'h60000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_op = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_res, out_lt, out_eq, out_gt, out_unord;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_compare_pipe #(.WE(WE), .WF(WF), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_lt    (out_lt),
    .out_eq    (out_eq),
    .out_gt    (out_gt),
    .out_unord (out_unord),
    .out_tag   (out_tag)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {out_res, out_lt, out_eq, out_gt, out_unord};
  endfunction

  // One isolated pair: checks no result after 1 cycle, result after 2.
  task automatic do_pair(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2:0] op,
                         input logic [TW-1:0] t, input logic [4:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_flg"}, 32'(flags()), 32'(exp));
    check({tag, "_tag"}, 32'(out_tag), 32'(t));
  endtask

  int idx, rcv, c;
  logic acc;
  logic [TW-1:0] held_tag;
  logic [4:0] held_flg;

  initial begin
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_pair("t1_lt", P1, P2, 3'd0, 4'h1, 5'b11000);
    do_pair("t2_ge", N1, P1, 3'd5, 4'h2, 5'b01000);
    do_pair("t2_ninf", NI, N1, 3'd0, 4'h3, 5'b11000);
    do_pair("t3_eq", PZ, NZ, 3'd2, 4'h4, 5'b10100);
    do_pair("t3_lt", PZ, NZ, 3'd0, 4'h5, 5'b00100);
    do_pair("t4_ne", NAN, P1, 3'd3, 4'h6, 5'b10001);
    do_pair("t4_lt", NAN, P1, 3'd0, 4'h7, 5'b00001);
    do_pair("t4_le", NAN, P1, 3'd1, 4'h8, 5'b00001);
    do_pair("t4_eq", NAN, P1, 3'd2, 4'h9, 5'b00001);
    do_pair("t4_gt", NAN, P1, 3'd4, 4'ha, 5'b00001);
    do_pair("t4_ge", NAN, P1, 3'd5, 4'hb, 5'b00001);
    do_pair("gt_neg", N1, NI, 3'd4, 4'hc, 5'b10010);
    do_pair("nz_vs_n1", NZ, N1, 3'd4, 4'hd, 5'b10010);
    do_pair("rsv6", P1, P2, 3'd6, 4'he, 5'b01000);
    do_pair("eq_p1", P1, P1, 3'd1, 4'hf, 5'b10100);

    // Stream 8 pairs with a 3-cycle downstream stall.
    idx = 0;
    rcv = 0;
    held_tag = '0;
    held_flg = '0;
    for (c = 0; c < 40 && rcv < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 5);
      in_valid = idx < 8;
      in_a = idx[0] ? P2 : P1;
      in_b = idx[0] ? P1 : P2;
      in_op = 3'd0;
      in_tag = TW'(idx);
      #1;
      if (c < 10)
        check("s_inrdy", 32'(in_ready), 32'(!(c >= 3 && c <= 5)));
      if (c == 3) begin
        held_tag = out_tag;
        held_flg = flags();
      end
      if (c == 4 || c == 5) begin
        check("s_hold_tag", 32'(out_tag), 32'(held_tag));
        check("s_hold_flg", 32'(flags()), 32'(held_flg));
      end
      if (out_valid && out_ready) begin
        check("s_tag", 32'(out_tag), 32'(rcv));
        check("s_flg", 32'(flags()),
              rcv[0] ? 32'b00010 : 32'b11000);
        rcv++;
      end
      acc = in_valid && in_ready;
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("s_count", 32'(rcv), 32'd8);
    @(negedge clk);
    check("s_nodup", 32'(out_valid), 32'd0);

    // Reset with two pairs in flight.
    @(negedge clk);
    in_valid = 1'b1;
    in_a = P1;
    in_b = P2;
    in_tag = 4'h1;
    @(negedge clk);
    in_tag = 4'h2;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("r_now", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("r_stale", 32'(out_valid), 32'd0);
    end
    do_pair("r_next", P2, P1, 3'd4, 4'h9, 5'b10010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
